cov_engine: RTL
===============

Name: cov_engine

Overview:
- Parametrised fixed-point covariance accelerator. It computes x_bar, y_bar and cov(X,Y) of N sample pairs in hardware, replacing the software program-3 loop.
- Shares the data memory with the CPU through one synchronous read/write port.
- Uses the same Start/Ack handshake and memory layout as program 3:
  - Core[0] = N
  - X samples at 1..N
  - Y samples at N+1..2N
  - Result high byte at 2N+1, low byte at 2N+2

Parameters:
- DW, 8: sample width in bits (unsigned integer samples).
- FRAC, 8: fraction bits of results. Result width RW = DW+FRAC.
- AW, 10: memory address width. Must satisfy 2^AW > 2*MAX_N+6.
- MAX_N, 255: largest legal N. N > MAX_N is clamped to MAX_N.

Ports:
- Clk, in, 1: system clock.
- Reset_n, in, 1: asynchronous active-low reset.
- Start, in, 1: launch request, level-sampled.
- Ack, out, 1: run complete.
- Mem_Addr, out, AW: memory address, used for both reads and writes.
- Mem_Rd, out, 1: read strobe. Data is returned on Mem_RdData in the following cycle.
- Mem_RdData, in, 8: read data.
- Mem_Wr, out, 1: write strobe. Write commits at the clock edge.
- Mem_WrData, out, 8: write data.
- Busy, out, 1: high in every state except IDLE and DONE.

Behaviour:
- Reset: Ack=0, Busy=0, Mem_Rd=0, Mem_Wr=0, Mem_Addr=0, Mem_WrData=0, state=IDLE, all accumulators 0.
- Reset asserted mid-operation aborts the run immediately. No further writes are issued.
- Handshake:
  - In IDLE or DONE, Start=1 moves to RD_N and drops Ack in that same edge.
  - Start asserted while Busy is ignored.
  - Ack stays 1 in DONE until the next Start.
- States: IDLE → RD_N → ACC_X → DIV_X → ACC_Y → DIV_Y → ACC_C → DIV_C → WR_HI → WR_LO → DONE.
- RD_N: read address 0 and latch N, 8 bits unsigned.
  - If N == 0, skip directly to WR_HI with result 0.
- ACC_X: issue reads at addresses 1..N back-to-back, one per cycle. Reads are pipelined so data for address k arrives while address k+1 is issued.
  - sumx += (X << FRAC), truncated to RW bits (wraps modulo 2^RW).
- DIV_X: x_bar = sumx / N, unsigned, truncated toward zero. Takes RW cycles in the divider.
- ACC_Y / DIV_Y: the same over addresses N+1..2N, producing y_bar.
- ACC_C: for i = 1..N, read X_i then Y_i (2 reads per pair).
  - dx = (X_i << FRAC) − x_bar, taken as RW-bit signed.
  - dy = (Y_i << FRAC) − y_bar, taken as RW-bit signed.
  - p = dx*dy, 2*RW-bit signed.
  - sumc += p >>> FRAC, truncated to RW bits, signed, wrapping.
- DIV_C: signed divide by N, truncated toward zero (negate, divide unsigned, negate).
- WR_HI: write result[RW-1:RW-8] to address 2N+1.
- WR_LO: write result[7:0] to address 2N+2.
- DONE: Ack=1, Busy=0.
- Mem_Rd and Mem_Wr are never high in the same cycle.
- Mem_Addr holds its last value when both strobes are low.

Optional Feature:
- Macro: COV_MEAN_WB_EN.
- Defined: after WR_LO, two extra states write x_bar hi/lo to 2N+3/2N+4 and y_bar hi/lo to 2N+5/2N+6, then go to DONE. These states add 4 cycles.
- Undefined: only the two result bytes are written, and addresses above 2N+2 are untouched.

Decomposition:
- Package cov_pkg holds:
  - the state enum
  - address offset constants (N_ADDR=0, RES_HI_OFS=1, RES_LO_OFS=2, MEAN_OFS=3)
  - the RW localparam helper
- One sub-module: seq_divider. It is a restoring divider, RW-bit dividend by 8-bit divisor, with a start/done handshake and a sign-magnitude wrapper. It has 1-cycle start and RW-cycle latency.

Test Plan:
1. N=3, X={1,2,3}, Y={10,20,27} → x_bar=0x0200, y_bar=0x1300; Core[7]=0x05, Core[8]=0xAA; Ack rises.
2. N=4, X={2,4,8,10}, Y={7,3,5,1} → x_bar=0x0600, y_bar=0x0400; result 0xFB00 (negative, truncation toward zero).
3. N=2, X={1,2}, Y={4,4} → x_bar=0x0180 (fractional mean); result 0x0000. With COV_MEAN_WB_EN: Core[7..10] = 01,80,04,00.
4. N=0 → Core[1]=Core[2]=0x00; no reads beyond address 0; Ack within 5 cycles of Start.
5. Pulse Reset_n low during ACC_C of test 1 → all outputs return to reset values asynchronously; Core[7..8] unchanged. A second Start then produces 0x05AA.
6. Start held high through the run, and a second Start pulse mid-run → both ignored; exactly one write pair; Ack stays high until Start is reasserted after DONE.

Source files
------------

// File: rtl/cov_pkg.sv
// Shared types and constants for the covariance engine: FSM state encoding,
// memory layout offsets and the result-width helper.
package cov_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD_N  = 4'd1,
        S_ACC_X = 4'd2,
        S_DIV_X = 4'd3,
        S_ACC_Y = 4'd4,
        S_DIV_Y = 4'd5,
        S_ACC_C = 4'd6,
        S_DIV_C = 4'd7,
        S_WR_HI = 4'd8,
        S_WR_LO = 4'd9,
        S_WR_XH = 4'd10,
        S_WR_XL = 4'd11,
        S_WR_YH = 4'd12,
        S_WR_YL = 4'd13,
        S_DONE  = 4'd14
    } state_e;

    localparam int N_ADDR     = 0;
    localparam int RES_HI_OFS = 1;
    localparam int RES_LO_OFS = 2;
    localparam int MEAN_OFS   = 3;

    function automatic int calc_rw(input int dw, input int frac);
        return dw + frac;
    endfunction

endpackage

// File: rtl/cov_engine_seq_divider.sv
// Restoring divider, RW-bit dividend by DVW-bit divisor, one quotient bit per
// cycle, with an optional sign-magnitude wrapper around the unsigned core.
module seq_divider #(
    parameter int RW  = 16,
    parameter int DVW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          signed_i,
    input  logic [RW-1:0] dividend_i,
    input  logic [DVW-1:0] divisor_i,
    output logic          done_o,
    output logic [RW-1:0] quotient_o
);

    localparam int CW = $clog2(RW);

    logic [RW-1:0]  quo_q;
    logic [DVW-1:0] rem_q;
    logic [DVW-1:0] dvs_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q;
    logic           busy_q;
    logic           done_q;
    logic [RW-1:0]  res_q;

    logic [DVW:0]   rem_sh_s;
    logic           ge_s;
    logic [DVW-1:0] rem_nx_s;
    logic [RW-1:0]  quo_nx_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh_s = {rem_q, quo_q[RW-1]};
        ge_s     = (rem_sh_s >= {1'b0, dvs_q});
        if (ge_s) begin
            rem_nx_s = DVW'(rem_sh_s - {1'b0, dvs_q});
        end else begin
            rem_nx_s = rem_sh_s[DVW-1:0];
        end
        quo_nx_s = {quo_q[RW-2:0], ge_s};
    end

    // Iteration state; the magnitude is loaded on start and sign restored at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            neg_q  <= signed_i & dividend_i[RW-1];
            quo_q  <= (signed_i && dividend_i[RW-1]) ? (RW'(0) - dividend_i) : dividend_i;
        end else if (busy_q) begin
            rem_q <= rem_nx_s;
            quo_q <= quo_nx_s;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(RW - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                res_q  <= neg_q ? (RW'(0) - quo_nx_s) : quo_nx_s;
            end else begin
                done_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = res_q;

endmodule

// File: rtl/cov_engine.sv
// Fixed-point covariance engine sharing one synchronous memory port with the CPU.
// Optional COV_MEAN_WB_EN also writes x_bar and y_bar after the result bytes.
module cov_engine
    import cov_pkg::*;
#(
    parameter int DW    = 8,
    parameter int FRAC  = 8,
    parameter int AW    = 10,
    parameter int MAX_N = 255
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    output logic          Ack,
    output logic [AW-1:0] Mem_Addr,
    output logic          Mem_Rd,
    input  logic [7:0]    Mem_RdData,
    output logic          Mem_Wr,
    output logic [7:0]    Mem_WrData,
    output logic          Busy
);

    localparam int RW = calc_rw(DW, FRAC);
    localparam int CW = $clog2(2 * MAX_N + 1);

    state_e        state_q, state_d;
    logic [7:0]    n_q, n_d;
    logic [CW-1:0] iss_q, iss_d, rcv_q, rcv_d;
    logic [RW-1:0] acc_q, acc_d, xbar_q, xbar_d, ybar_q, ybar_d, xs_q, xs_d;
    logic [7:0]    res_lo_q, res_lo_d, wrd_q, wrd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ack_q, ack_d, rd_q, rd_d, wr_q, wr_d, busy_q, rvalid_q;

    logic              div_start_s, div_signed_s, div_done_s;
    logic [RW-1:0]     div_dividend_s, div_quo_s;
    logic [7:0]        n_rd_s;
    logic [RW-1:0]     samp_s, acc_add_s, acc_cov_s, cov_inc_s;
    logic signed [RW-1:0]   dx_s, dy_s;
    logic signed [2*RW-1:0] prod_s;
    logic [AW-1:0]     n_a_s, two_n_a_s, base_s, half_a_s;
    logic [CW-1:0]     n_c_s, two_n_c_s;

    assign n_rd_s    = (Mem_RdData > 8'(MAX_N)) ? 8'(MAX_N) : Mem_RdData;
    assign samp_s    = {DW'(Mem_RdData), {FRAC{1'b0}}};
    assign dx_s      = xs_q - xbar_q;
    assign dy_s      = samp_s - ybar_q;
    assign prod_s    = dx_s * dy_s;
    assign cov_inc_s = RW'(prod_s >>> FRAC);
    assign acc_add_s = acc_q + samp_s;
    assign acc_cov_s = acc_q + cov_inc_s;
    assign n_a_s     = AW'(n_q);
    assign two_n_a_s = AW'({n_q, 1'b0});
    assign half_a_s  = AW'(iss_q >> 1);
    assign n_c_s     = CW'(n_q);
    assign two_n_c_s = CW'({n_q, 1'b0});
    assign base_s    = (state_q == S_ACC_X) ? AW'(1) : (n_a_s + AW'(1));

    seq_divider #(.RW(RW), .DVW(8)) u_div (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .start_i    (div_start_s),
        .signed_i   (div_signed_s),
        .dividend_i (div_dividend_s),
        .divisor_i  (n_q),
        .done_o     (div_done_s),
        .quotient_o (div_quo_s)
    );

    // Next-state, memory strobes and datapath updates.
    always_comb begin
        state_d = state_q;   n_d = n_q;       iss_d = iss_q;   rcv_d = rcv_q;
        acc_d = acc_q;       xbar_d = xbar_q; ybar_d = ybar_q; xs_d = xs_q;
        res_lo_d = res_lo_q; ack_d = ack_q;   addr_d = addr_q; wrd_d = wrd_q;
        rd_d = 1'b0;         wr_d = 1'b0;
        div_start_s = 1'b0;  div_signed_s = 1'b0; div_dividend_s = acc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_RD_N; rd_d = 1'b1; addr_d = AW'(N_ADDR); ack_d = 1'b0;
                    acc_d = '0; xbar_d = '0; ybar_d = '0; res_lo_d = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RD_N: begin
                if (rvalid_q) begin
                    n_d = n_rd_s;
                    if (n_rd_s == 8'd0) begin
                        state_d = S_WR_HI; wr_d = 1'b1;
                        addr_d = AW'(RES_HI_OFS); wrd_d = 8'd0;
                    end else begin
                        state_d = S_ACC_X; rd_d = 1'b1; addr_d = AW'(1);
                        iss_d = CW'(1); rcv_d = '0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_ACC_X, S_ACC_Y: begin
                if (iss_q < n_c_s) begin
                    rd_d = 1'b1; addr_d = base_s + AW'(iss_q); iss_d = iss_q + CW'(1);
                end else begin
                    rd_d = 1'b0;
                end
                if (rvalid_q) begin
                    acc_d = acc_add_s; rcv_d = rcv_q + CW'(1);
                    if (rcv_q == n_c_s - CW'(1)) begin
                        state_d = (state_q == S_ACC_X) ? S_DIV_X : S_DIV_Y;
                        div_start_s = 1'b1; div_dividend_s = acc_add_s;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DIV_X, S_DIV_Y: begin
                if (div_done_s) begin
                    rd_d = 1'b1; iss_d = CW'(1); rcv_d = '0; acc_d = '0;
                    if (state_q == S_DIV_X) begin
                        xbar_d = div_quo_s; state_d = S_ACC_Y; addr_d = n_a_s + AW'(1);
                    end else begin
                        ybar_d = div_quo_s; state_d = S_ACC_C; addr_d = AW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            // Interleaved X_i, Y_i reads; even receive index is X, odd is Y.
            S_ACC_C: begin
                if (iss_q < two_n_c_s) begin
                    rd_d = 1'b1; iss_d = iss_q + CW'(1);
                    addr_d = iss_q[0] ? (n_a_s + AW'(1) + half_a_s) : (AW'(1) + half_a_s);
                end else begin
                    rd_d = 1'b0;
                end
                if (rvalid_q) begin
                    rcv_d = rcv_q + CW'(1);
                    if (!rcv_q[0]) begin
                        xs_d = samp_s;
                    end else begin
                        acc_d = acc_cov_s;
                        if (rcv_q == two_n_c_s - CW'(1)) begin
                            state_d = S_DIV_C; div_start_s = 1'b1;
                            div_signed_s = 1'b1; div_dividend_s = acc_cov_s;
                        end else begin
                            state_d = state_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DIV_C: begin
                if (div_done_s) begin
                    state_d = S_WR_HI; wr_d = 1'b1; res_lo_d = div_quo_s[7:0];
                    addr_d = two_n_a_s + AW'(RES_HI_OFS); wrd_d = div_quo_s[RW-1 -: 8];
                end else begin
                    state_d = state_q;
                end
            end
            S_WR_HI: begin
                state_d = S_WR_LO; wr_d = 1'b1;
                addr_d = two_n_a_s + AW'(RES_LO_OFS); wrd_d = res_lo_q;
            end
`ifdef COV_MEAN_WB_EN
            S_WR_LO: begin
                state_d = S_WR_XH; wr_d = 1'b1;
                addr_d = two_n_a_s + AW'(MEAN_OFS); wrd_d = xbar_q[RW-1 -: 8];
            end
            S_WR_XH: begin
                state_d = S_WR_XL; wr_d = 1'b1;
                addr_d = two_n_a_s + AW'(MEAN_OFS + 1); wrd_d = xbar_q[7:0];
            end
            S_WR_XL: begin
                state_d = S_WR_YH; wr_d = 1'b1;
                addr_d = two_n_a_s + AW'(MEAN_OFS + 2); wrd_d = ybar_q[RW-1 -: 8];
            end
            S_WR_YH: begin
                state_d = S_WR_YL; wr_d = 1'b1;
                addr_d = two_n_a_s + AW'(MEAN_OFS + 3); wrd_d = ybar_q[7:0];
            end
            S_WR_YL: begin
                state_d = S_DONE; ack_d = 1'b1;
            end
`else
            S_WR_LO: begin
                state_d = S_DONE; ack_d = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE; n_q <= 8'd0; iss_q <= '0; rcv_q <= '0;
            acc_q <= '0; xbar_q <= '0; ybar_q <= '0; xs_q <= '0;
            res_lo_q <= 8'd0; wrd_q <= 8'd0; addr_q <= '0;
            ack_q <= 1'b0; rd_q <= 1'b0; wr_q <= 1'b0; busy_q <= 1'b0; rvalid_q <= 1'b0;
        end else begin
            state_q <= state_d; n_q <= n_d; iss_q <= iss_d; rcv_q <= rcv_d;
            acc_q <= acc_d; xbar_q <= xbar_d; ybar_q <= ybar_d; xs_q <= xs_d;
            res_lo_q <= res_lo_d; wrd_q <= wrd_d; addr_q <= addr_d;
            ack_q <= ack_d; rd_q <= rd_d; wr_q <= wr_d; rvalid_q <= rd_q;
            busy_q <= !((state_d == S_IDLE) || (state_d == S_DONE));
        end
    end

    assign Ack        = ack_q;
    assign Busy       = busy_q;
    assign Mem_Rd     = rd_q;
    assign Mem_Wr     = wr_q;
    assign Mem_Addr   = addr_q;
    assign Mem_WrData = wrd_q;

endmodule
